// File: rtl/cordic_pkg.sv
// Shared types and constants for the CORDIC vectoring sequencer and its datapath muxes.
`default_nettype none
`timescale 1ns/1ps

package cordic_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_ITER = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic [1:0] SEL_LOAD    = 2'd0;
  localparam logic [1:0] SEL_ROT_POS = 2'd1;
  localparam logic [1:0] SEL_ROT_NEG = 2'd2;
  localparam logic [1:0] SEL_HOLD    = 2'd3;

  localparam int DEF_WORD_WIDTH = 16;
  localparam int DEF_ITERATIONS = 12;
  localparam int DEF_CNT_WIDTH  = 4;

endpackage

`default_nettype wire

// File: rtl/cordic_iter_counter.sv
// Micro-rotation index counter: clear has priority, wraps to 0 after the terminal count.
`default_nettype none
`timescale 1ns/1ps

module cordic_iter_counter #(
  parameter int ITERATIONS = 12,
  parameter int CNT_WIDTH  = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  input  logic                 en,
  output logic [CNT_WIDTH-1:0] cnt,
  output logic                 tc
);

  localparam logic [CNT_WIDTH-1:0] LAST_IDX = CNT_WIDTH'(ITERATIONS - 1);

  logic [CNT_WIDTH-1:0] cnt_q;
  logic [CNT_WIDTH-1:0] cnt_d;

  assign tc  = (cnt_q == LAST_IDX);
  assign cnt = cnt_q;

  // Returning to 0 at the terminal count keeps ITERATIONS == 2**CNT_WIDTH overflow-free.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = tc ? '0 : cnt_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/cordic_vectoring_ctrl.sv
// CORDIC vectoring-mode sequencer: drives the x/y/z mux select and register enable,
// steps the iteration index, and handshakes start/done.
`default_nettype none
`timescale 1ns/1ps

module cordic_vectoring_ctrl
  import cordic_pkg::*;
#(
  parameter int WORD_WIDTH = DEF_WORD_WIDTH,
  parameter int ITERATIONS = DEF_ITERATIONS,
  parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic                 y_sign,
  output logic [1:0]           sel,
  output logic                 reg_en,
  output logic [CNT_WIDTH-1:0] iter_idx,
  output logic                 busy,
  output logic                 done
);

  if (WORD_WIDTH < 1 || ITERATIONS < 1 || ITERATIONS > 2**CNT_WIDTH) begin : g_param_check
    $error("cordic_vectoring_ctrl: illegal WORD_WIDTH/ITERATIONS/CNT_WIDTH combination");
  end

  state_t state_q;
  state_t state_d;
  logic   cnt_clr;
  logic   cnt_en;
  logic   cnt_tc;

  assign cnt_en  = (state_q == ST_ITER);
  assign cnt_clr = (state_q != ST_ITER) || abort;

  cordic_iter_counter #(
    .ITERATIONS(ITERATIONS),
    .CNT_WIDTH (CNT_WIDTH)
  ) u_iter_counter (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (cnt_clr),
    .en   (cnt_en),
    .cnt  (iter_idx),
    .tc   (cnt_tc)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_LOAD;
      ST_LOAD: state_d = abort ? ST_IDLE : ST_ITER;
      ST_ITER: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (cnt_tc) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = start ? ST_LOAD : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Only sel looks at a live input: the rotation direction must track y's sign in the same cycle.
  always_comb begin
    sel = SEL_HOLD;
    case (state_q)
      ST_LOAD: sel = SEL_LOAD;
      ST_ITER: sel = y_sign ? SEL_ROT_POS : SEL_ROT_NEG;
      default: sel = SEL_HOLD;
    endcase
  end

  assign reg_en = (state_q == ST_LOAD) || (state_q == ST_ITER);
  assign busy   = reg_en;
  assign done   = (state_q == ST_DONE);

endmodule

`default_nettype wire

// File: tb/tb_cordic_vectoring_ctrl.sv
// Directed, table-driven bench for cordic_vectoring_ctrl with ITERATIONS=12.
`default_nettype none
`timescale 1ns/1ps

module tb_cordic_vectoring_ctrl;

  localparam int ITER = 12;

  typedef struct {
    bit         start;
    bit         abort;
    bit         y;
    logic [8:0] exp;   // {sel, reg_en, iter_idx, busy, done}
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       y_sign = 1'b0;
  logic [1:0] sel;
  logic       reg_en;
  logic [3:0] iter_idx;
  logic       busy;
  logic       done;

  int checks = 0;
  int errors = 0;
  vec_t q1[$];
  vec_t q2[$];

  cordic_vectoring_ctrl #(.WORD_WIDTH(16), .ITERATIONS(ITER), .CNT_WIDTH(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .abort   (abort),
    .y_sign  (y_sign),
    .sel     (sel),
    .reg_en  (reg_en),
    .iter_idx(iter_idx),
    .busy    (busy),
    .done    (done)
  );

  always #2 clk = ~clk;

  function automatic logic [8:0] eb(input logic [1:0] s, input logic en, input logic [3:0] idx,
                                    input logic b, input logic d);
    return {s, en, idx, b, d};
  endfunction

  function automatic vec_t v(input bit st, input bit ab, input bit y, input logic [8:0] e);
    vec_t r;
    r.start = st; r.abort = ab; r.y = y; r.exp = e;
    return r;
  endfunction

  function automatic logic [8:0] idle_e();
    return eb(2'd3, 1'b0, 4'd0, 1'b0, 1'b0);
  endfunction

  task automatic check(input string name, input logic [8:0] e);
    logic [8:0] got;
    got = {sel, reg_en, iter_idx, busy, done};
    checks++;
    if (got !== e) begin
      errors++;
      $display("FAIL %s: got sel=%0d reg_en=%0b iter_idx=%0d busy=%0b done=%0b, expected sel=%0d reg_en=%0b iter_idx=%0d busy=%0b done=%0b",
               name, got[8:7], got[6], got[5:2], got[1], got[0], e[8:7], e[6], e[5:2], e[1], e[0]);
    end
  endtask

  // One full operation after the start cycle: LOAD, ITER x12 with alternating y_sign, DONE.
  task automatic push_op(inout vec_t q[$], input bit s_run, input bit s_done, input bit a_done);
    q.push_back(v(s_run, 1'b0, 1'b0, eb(2'd0, 1'b1, 4'd0, 1'b1, 1'b0)));
    for (int i = 0; i < ITER; i++) begin
      bit y;
      y = i[0];
      q.push_back(v(s_run, 1'b0, y, eb(y ? 2'd1 : 2'd2, 1'b1, 4'(i), 1'b1, 1'b0)));
    end
    q.push_back(v(s_done, a_done, 1'b0, eb(2'd3, 1'b0, 4'd0, 1'b0, 1'b1)));
  endtask

  task automatic run_queue(input string tag, inout vec_t q[$]);
    for (int i = 0; i < q.size(); i++) begin
      @(negedge clk);
      start  = q[i].start;
      abort  = q[i].abort;
      y_sign = q[i].y;
      #1;
      check($sformatf("%s[%0d]", tag, i), q[i].exp);
    end
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // Idle behaviour and abort ignored while idle.
    q1.push_back(v(0, 0, 0, idle_e()));
    q1.push_back(v(0, 1, 0, idle_e()));
    q1.push_back(v(0, 0, 1, idle_e()));
    // Nominal operation, then IDLE.
    q1.push_back(v(1, 0, 0, idle_e()));
    push_op(q1, 1'b0, 1'b0, 1'b0);
    q1.push_back(v(0, 0, 0, idle_e()));
    // Back-to-back with start held high.
    q1.push_back(v(1, 0, 0, idle_e()));
    push_op(q1, 1'b1, 1'b1, 1'b0);
    push_op(q1, 1'b1, 1'b0, 1'b0);
    q1.push_back(v(0, 0, 0, idle_e()));
    // start and abort together in DONE: start wins.
    q1.push_back(v(1, 0, 0, idle_e()));
    push_op(q1, 1'b0, 1'b1, 1'b1);
    push_op(q1, 1'b0, 1'b0, 1'b0);
    q1.push_back(v(0, 0, 0, idle_e()));
    // Abort at iter_idx 5, no done, then a full-latency restart.
    q1.push_back(v(1, 0, 0, idle_e()));
    q1.push_back(v(0, 0, 0, eb(2'd0, 1'b1, 4'd0, 1'b1, 1'b0)));
    for (int i = 0; i <= 5; i++)
      q1.push_back(v(0, (i == 5), 1'b1, eb(2'd1, 1'b1, 4'(i), 1'b1, 1'b0)));
    q1.push_back(v(0, 0, 0, idle_e()));
    q1.push_back(v(0, 0, 0, idle_e()));
    q1.push_back(v(1, 0, 0, idle_e()));
    push_op(q1, 1'b0, 1'b0, 1'b0);
    q1.push_back(v(0, 0, 0, idle_e()));
    // Abort during LOAD.
    q1.push_back(v(1, 0, 0, idle_e()));
    q1.push_back(v(0, 1, 0, eb(2'd0, 1'b1, 4'd0, 1'b1, 1'b0)));
    q1.push_back(v(0, 0, 0, idle_e()));
    q1.push_back(v(0, 0, 0, idle_e()));

    #3;
    check("reset_state", idle_e());
    @(negedge clk);
    rst_n = 1'b1;
    run_queue("tbl", q1);

    // Asynchronous reset in the middle of ITER.
    @(negedge clk);
    start = 1'b1; abort = 1'b0; y_sign = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    #1;
    check("pre_reset_iter7", eb(2'd2, 1'b1, 4'd7, 1'b1, 1'b0));
    #0.5;
    rst_n = 1'b0;
    #0.2;
    check("async_reset_immediate", idle_e());
    @(negedge clk);
    #1;
    check("reset_held", idle_e());
    rst_n = 1'b1;

    q2.push_back(v(0, 0, 0, idle_e()));
    q2.push_back(v(1, 0, 0, idle_e()));
    push_op(q2, 1'b0, 1'b0, 1'b0);
    q2.push_back(v(0, 0, 0, idle_e()));
    run_queue("post_reset", q2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
